// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: CPU/display request-response handshakes and RAM-side bus
// shared by mem_port_arbiter and whatever drives it.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dsp_req;
    logic [ADDR_W-1:0] dsp_addr;
    logic              dsp_gnt;
    logic              dsp_rvalid;
    logic [DATA_W-1:0] dsp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dsp_req, dsp_addr, mem_rdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata, dsp_gnt, dsp_rvalid, dsp_rdata,
               mem_addr, mem_wdata, mem_we, busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dsp_req, dsp_addr, mem_rdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata, dsp_gnt, dsp_rvalid, dsp_rdata,
               mem_addr, mem_wdata, mem_we, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port sync RAM between CPU (priority) and
// display reader (starvation-bounded), one access per ACCESS/RESP pair.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state;
    logic              owner_dsp;
    logic              we_q;
    logic [SW-1:0]     starve;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              mem_we_q;
    logic              cpu_gnt_q;
    logic              dsp_gnt_q;
    logic              cpu_rvalid_q;
    logic              dsp_rvalid_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dsp_rdata_q;
    logic              busy_q;
    logic              dsp_win;
    logic              cpu_win;

    always_comb begin
        dsp_win = bus.dsp_req && (!bus.cpu_req || starve == LIM);
        cpu_win = bus.cpu_req && !dsp_win;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            owner_dsp    <= 1'b0;
            we_q         <= 1'b0;
            starve       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            cpu_gnt_q    <= 1'b0;
            dsp_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dsp_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dsp_rdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            cpu_gnt_q    <= 1'b0;
            dsp_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            dsp_rvalid_q <= 1'b0;
            mem_we_q     <= 1'b0;
            // RAM data is only on mem_rdata during RESP; keep it for later cycles
            if (cpu_rvalid_q) cpu_rdata_q <= bus.mem_rdata;
            if (dsp_rvalid_q) dsp_rdata_q <= bus.mem_rdata;
            case (state)
                ACCESS: begin
                    state        <= RESP;
                    busy_q       <= 1'b1;
                    cpu_rvalid_q <= !owner_dsp && !we_q;
                    dsp_rvalid_q <= owner_dsp;
                end
                default: begin
                    starve <= (!bus.dsp_req || dsp_win) ? '0 :
                              (starve == LIM) ? starve : starve + 1'b1;
                    if (cpu_win || dsp_win) begin
                        state      <= ACCESS;
                        busy_q     <= 1'b1;
                        owner_dsp  <= dsp_win;
                        we_q       <= cpu_win && bus.cpu_we;
                        mem_we_q   <= cpu_win && bus.cpu_we;
                        mem_addr_q <= dsp_win ? bus.dsp_addr : bus.cpu_addr;
                        cpu_gnt_q  <= cpu_win;
                        dsp_gnt_q  <= dsp_win;
                        if (cpu_win) mem_wdata_q <= bus.cpu_wdata;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.cpu_gnt    = cpu_gnt_q;
    assign bus.dsp_gnt    = dsp_gnt_q;
    assign bus.cpu_rvalid = cpu_rvalid_q;
    assign bus.dsp_rvalid = dsp_rvalid_q;
    assign bus.cpu_rdata  = cpu_rvalid_q ? bus.mem_rdata : cpu_rdata_q;
    assign bus.dsp_rdata  = dsp_rvalid_q ? bus.mem_rdata : dsp_rdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a RAM model; read data checked by a
// scoreboard monitor, cycle timing checked inline.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [15:0] cpu_q[$];
    logic [15:0] dsp_q[$];
    logic [15:0] ram [0:65535];
    logic        load_en = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(posedge clk) begin
        if (load_en) ram[load_addr] <= load_data;
        else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.cpu_rvalid) begin
            if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1, 0);
            else check("cpu_rdata", {16'h0, bus.cpu_rdata}, {16'h0, cpu_q.pop_front()});
        end
        if (bus.dsp_rvalid) begin
            if (dsp_q.size() == 0) check("dsp_rvalid_unexpected", 1, 0);
            else check("dsp_rdata", {16'h0, bus.dsp_rdata}, {16'h0, dsp_q.pop_front()});
        end
        if (bus.cpu_gnt || bus.dsp_gnt) check("gnt_exclusive", bus.cpu_gnt & bus.dsp_gnt, 0);
        if (bus.cpu_rvalid || bus.dsp_rvalid) check("rvalid_exclusive", bus.cpu_rvalid & bus.dsp_rvalid, 0);
    end

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk) #1;
        load_addr = a;
        load_data = d;
        load_en = 1'b1;
        @(posedge clk) #1;
        load_en = 1'b0;
    endtask

    task automatic cpu_acc(input logic we, input logic [15:0] a, input logic [15:0] d,
                           input logic [15:0] exp, output int lat);
        logic ok;
        ok = 1'b0;
        lat = 0;
        if (!we) cpu_q.push_back(exp);
        @(posedge clk) #1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = a;
        bus.cpu_wdata = d;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            lat++;
            if (bus.cpu_gnt) ok = 1'b1;
        end
        check("cpu_gnt_seen", ok, 1);
        check("cpu_mem_addr", bus.mem_addr, a);
        check("cpu_mem_we", bus.mem_we, we);
        if (we) check("cpu_mem_wdata", bus.mem_wdata, d);
        @(posedge clk) #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("cpu_rvalid_after_gnt", bus.cpu_rvalid, !we);
        check("mem_we_one_cycle", bus.mem_we, 0);
    endtask

    task automatic dsp_rd(input logic [15:0] a, input logic [15:0] exp);
        logic ok;
        ok = 1'b0;
        dsp_q.push_back(exp);
        @(posedge clk) #1;
        bus.dsp_req = 1'b1;
        bus.dsp_addr = a;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus.dsp_gnt) ok = 1'b1;
        end
        check("dsp_gnt_seen", ok, 1);
        check("dsp_mem_addr", bus.mem_addr, a);
        @(posedge clk) #1;
        bus.dsp_req = 1'b0;
        @(negedge clk);
        check("dsp_rvalid_after_gnt", bus.dsp_rvalid, 1);
    endtask

    task automatic starve_run();
        int n;
        logic got;
        n = 0;
        got = 1'b0;
        @(posedge clk) #1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0050;
        bus.dsp_req = 1'b1;
        bus.dsp_addr = 16'h0070;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (bus.cpu_gnt) begin
                n++;
                cpu_q.push_back(16'h5555);
            end
            if (bus.dsp_gnt) begin
                got = 1'b1;
                dsp_q.push_back(16'h7777);
            end
        end
        check("starve_dsp_gnt_seen", got, 1);
        check("starve_cpu_wins_before_dsp", n, 4);
        @(posedge clk) #1;
        bus.dsp_req = 1'b0;
        got = 1'b0;
        n = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (bus.dsp_gnt) n++;
            if (bus.cpu_gnt) begin
                got = 1'b1;
                cpu_q.push_back(16'h5555);
            end
        end
        check("starve_cpu_next", got, 1);
        check("starve_no_extra_dsp", n, 0);
        @(posedge clk) #1;
        bus.cpu_req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cpu_gnt"}, bus.cpu_gnt, 0);
        check({tag, "_dsp_gnt"}, bus.dsp_gnt, 0);
        check({tag, "_cpu_rvalid"}, bus.cpu_rvalid, 0);
        check({tag, "_dsp_rvalid"}, bus.dsp_rvalid, 0);
        check({tag, "_mem_we"}, bus.mem_we, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_mem_addr"}, bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_cpu_rdata"}, bus.cpu_rdata, 0);
        check({tag, "_dsp_rdata"}, bus.dsp_rdata, 0);
    endtask

    initial begin
        int lat;
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.dsp_req = 1'b0;
        bus.dsp_addr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk) #1;
        reset = 1'b1;
        poke(16'h0010, 16'hBEEF);
        poke(16'h0050, 16'h5555);
        poke(16'h0060, 16'h6666);
        poke(16'h0070, 16'h7777);
        poke(16'h0080, 16'h8888);

        // single read: gnt on second sampled cycle, rvalid one cycle later
        cpu_acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, lat);
        check("read_latency", lat, 2);

        cpu_acc(1'b1, 16'h0020, 16'h1234, 16'h0000, lat);
        cpu_acc(1'b0, 16'h0020, 16'h0000, 16'h1234, lat);

        // simultaneous requests
        cpu_q.push_back(16'h5555);
        dsp_q.push_back(16'h6666);
        @(posedge clk) #1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0050;
        bus.dsp_req = 1'b1;
        bus.dsp_addr = 16'h0060;
        @(negedge clk);
        check("sim_n_busy", bus.busy, 0);
        @(negedge clk);
        check("sim_n1_cpu_gnt", bus.cpu_gnt, 1);
        check("sim_n1_busy", bus.busy, 1);
        check("sim_n1_addr", bus.mem_addr, 16'h0050);
        @(posedge clk) #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("sim_n2_cpu_rvalid", bus.cpu_rvalid, 1);
        check("sim_n2_dsp_gnt", bus.dsp_gnt, 0);
        @(negedge clk);
        check("sim_n3_dsp_gnt", bus.dsp_gnt, 1);
        check("sim_n3_addr", bus.mem_addr, 16'h0060);
        @(posedge clk) #1;
        bus.dsp_req = 1'b0;
        @(negedge clk);
        check("sim_n4_dsp_rvalid", bus.dsp_rvalid, 1);
        repeat (2) @(posedge clk);

        // second run only shows 4 CPU wins again if the counter cleared
        starve_run();
        starve_run();

        // reset during a read ACCESS: no rvalid, everything back to reset values
        @(posedge clk) #1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = 16'h0080;
        @(negedge clk);
        @(negedge clk);
        check("rst_rd_gnt", bus.cpu_gnt, 1);
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_rd");
        @(negedge clk);
        check("rst_rd_no_rvalid", bus.cpu_rvalid, 0);
        @(posedge clk) #1;
        reset = 1'b1;
        cpu_acc(1'b0, 16'h0080, 16'h0000, 16'h8888, lat);

        // reset during a write ACCESS: write already committed
        @(posedge clk) #1;
        bus.cpu_req = 1'b1;
        bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h0090;
        bus.cpu_wdata = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_mem_we", bus.mem_we, 1);
        reset = 1'b0;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_wr");
        @(posedge clk) #1;
        reset = 1'b1;
        cpu_acc(1'b0, 16'h0090, 16'h0000, 16'h9999, lat);
        cpu_acc(1'b0, 16'h0010, 16'h0000, 16'hBEEF, lat);
        dsp_rd(16'h0060, 16'h6666);

        // idle hold
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_busy", bus.busy, 0);
            check("idle_mem_we", bus.mem_we, 0);
            check("idle_cpu_rdata", bus.cpu_rdata, 16'hBEEF);
            check("idle_dsp_rdata", bus.dsp_rdata, 16'h6666);
        end

        check("cpu_queue_drained", cpu_q.size(), 0);
        check("dsp_queue_drained", dsp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
